// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle controller and the MIPS datapath.
// The master side is the controller; the slave side is the datapath that owns the IR and ALU.
interface mc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_wr;
  logic             ir_wr;
  logic             rf_wr;
  logic             dm_wr;
  logic [1:0]       npc_sel;
  logic [1:0]       ext_op;
  logic [1:0]       alu_op;
  logic             alu_src_b;
  logic [1:0]       wr_sel;
  logic [1:0]       wd_sel;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state;

  modport master (
    input  op, funct, zero,
    output pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, ext_op, alu_op, alu_src_b,
           wr_sel, wd_sel, illegal, instr_done, instr_cnt, state
  );

  modport slave (
    output op, funct, zero,
    input  pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, ext_op, alu_op, alu_src_b,
           wr_sel, wd_sel, illegal, instr_done, instr_cnt, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing,
// datapath enables and selects, and a retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DCD = 4'd1, S_EXE = 4'd2, S_ALUWB = 4'd3,
    S_MA    = 4'd4, S_MR  = 4'd5, S_MEMWB = 4'd6, S_MW = 4'd7,
    S_BR    = 4'd8, S_JMP = 4'd9, S_HALT = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic pc_wr, ir_wr, rf_wr, dm_wr, alu_src_b, illegal, instr_done;
  logic [1:0] npc_sel, ext_op, alu_op, wr_sel, wd_sel;

  assign is_r    = (bus.op == 6'b000000);
  assign is_addu = is_r && (bus.funct == 6'b100001);
  assign is_subu = is_r && (bus.funct == 6'b100011);
  assign is_jr   = is_r && (bus.funct == 6'b001000);
  assign is_ori  = (bus.op == 6'b001101);
  assign is_lui  = (bus.op == 6'b001111);
  assign is_lw   = (bus.op == 6'b100011);
  assign is_sw   = (bus.op == 6'b101011);
  assign is_beq  = (bus.op == 6'b000100);
  assign is_j    = (bus.op == 6'b000010);
  assign is_jal  = (bus.op == 6'b000011);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    rf_wr      = 1'b0;
    dm_wr      = 1'b0;
    npc_sel    = 2'b00;
    ext_op     = 2'b00;
    alu_op     = 2'b00;
    alu_src_b  = 1'b0;
    wr_sel     = 2'b00;
    wd_sel     = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXE;
        else if (is_lw || is_sw)                    state_d = S_MA;
        else if (is_beq)                            state_d = S_BR;
        else if (is_j || is_jal || is_jr)           state_d = S_JMP;
        else begin
          illegal = 1'b1;
          state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end
      end
      S_EXE: begin
        if (is_subu) alu_op = 2'b01;
        else if (is_ori || is_lui) begin
          alu_op    = 2'b10;
          alu_src_b = 1'b1;
          ext_op    = is_lui ? 2'b10 : 2'b00;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_wr      = 1'b1;
        wr_sel     = is_r ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MA: begin
        alu_src_b = 1'b1;
        ext_op    = 2'b01;
        state_d   = is_lw ? S_MR : S_MW;
      end
      S_MR:    state_d = S_MEMWB;
      S_MEMWB: begin
        rf_wr      = 1'b1;
        wd_sel     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MW: begin
        dm_wr      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      // Branch is the one Mealy output: PC loads only when the compare hit.
      S_BR: begin
        alu_op     = 2'b01;
        ext_op     = 2'b01;
        npc_sel    = 2'b01;
        pc_wr      = bus.zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        npc_sel    = is_jr ? 2'b11 : 2'b10;
        instr_done = 1'b1;
        if (is_jal) begin
          rf_wr  = 1'b1;
          wr_sel = 2'b10;
          wd_sel = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every write strobe so an abandoned instruction leaves no trace.
  assign bus.pc_wr      = pc_wr & ~rst;
  assign bus.ir_wr      = ir_wr & ~rst;
  assign bus.rf_wr      = rf_wr & ~rst;
  assign bus.dm_wr      = dm_wr & ~rst;
  assign bus.illegal    = illegal & ~rst;
  assign bus.npc_sel    = npc_sel;
  assign bus.ext_op     = ext_op;
  assign bus.alu_op     = alu_op;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.wr_sel     = wr_sel;
  assign bus.wd_sel     = wd_sel;
  assign bus.instr_done = instr_done;
  assign bus.instr_cnt  = cnt_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: three instances (default, halt-on-illegal, 4-bit counter) driven
// with the same instruction stream and checked against an instruction-level reference model.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(16)) bus_a ();
  mc_ctrl_if #(.CNT_W(16)) bus_h ();
  mc_ctrl_if #(.CNT_W(4))  bus_s ();

  mc_ctrl #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  mc_ctrl #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h.master));
  mc_ctrl #(.CNT_W(4),  .HALT_ON_ILLEGAL(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.master));

  // {pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, ext_op, alu_op, alu_src_b, wr_sel, wd_sel, illegal, instr_done, state}
  logic [20:0] obs_a, obs_h, obs_s;
  assign obs_a = {bus_a.pc_wr, bus_a.ir_wr, bus_a.rf_wr, bus_a.dm_wr, bus_a.npc_sel, bus_a.ext_op,
                  bus_a.alu_op, bus_a.alu_src_b, bus_a.wr_sel, bus_a.wd_sel, bus_a.illegal,
                  bus_a.instr_done, bus_a.state};
  assign obs_h = {bus_h.pc_wr, bus_h.ir_wr, bus_h.rf_wr, bus_h.dm_wr, bus_h.npc_sel, bus_h.ext_op,
                  bus_h.alu_op, bus_h.alu_src_b, bus_h.wr_sel, bus_h.wd_sel, bus_h.illegal,
                  bus_h.instr_done, bus_h.state};
  assign obs_s = {bus_s.pc_wr, bus_s.ir_wr, bus_s.rf_wr, bus_s.dm_wr, bus_s.npc_sel, bus_s.ext_op,
                  bus_s.alu_op, bus_s.alu_src_b, bus_s.wr_sel, bus_s.wd_sel, bus_s.illegal,
                  bus_s.instr_done, bus_s.state};

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct {
    logic [31:0] ir;
    logic        z;
    int          len;
    logic [19:0] path;
    int          pcw;
    int          rfw;
    int          dmw;
    int          ill;
    int          done;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cnt_a, cnt_h, cnt_s;
  bit halted;

  function automatic kind_t decode(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    case (op)
      6'h00: begin
        if (fn == 6'h21) return K_ADDU;
        if (fn == 6'h23) return K_SUBU;
        if (fn == 6'h08) return K_JR;
        return K_ILL;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int inst_len(input kind_t k);
    case (k)
      K_ILL:                     return 2;
      K_BEQ, K_J, K_JAL, K_JR:   return 3;
      K_LW:                      return 5;
      default:                   return 4;
    endcase
  endfunction

  // Which state an instruction of kind k occupies in its ph-th cycle.
  function automatic int path_state(input kind_t k, input int ph);
    if (ph == 0) return 0;
    if (ph == 1) return 1;
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: return (ph == 2) ? 2 : 3;
      K_LW:  return (ph == 2) ? 4 : ((ph == 3) ? 5 : 6);
      K_SW:  return (ph == 2) ? 4 : 7;
      K_BEQ: return 8;
      K_J, K_JAL, K_JR: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic logic [20:0] outputs(input int st, input kind_t k, input logic z);
    logic pc, ir, rf, dm, asb, ill, done;
    logic [1:0] npc, ext, alu, wr, wd;
    logic [3:0] s4;
    {pc, ir, rf, dm, asb, ill, done} = '0;
    {npc, ext, alu, wr, wd} = '0;
    s4 = st[3:0];
    case (st)
      0: begin pc = 1; ir = 1; end
      1: ill = (k == K_ILL);
      2: begin
        if (k == K_SUBU) alu = 2'b01;
        if (k == K_ORI) begin alu = 2'b10; asb = 1; ext = 2'b00; end
        if (k == K_LUI) begin alu = 2'b10; asb = 1; ext = 2'b10; end
      end
      3: begin rf = 1; done = 1; wr = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00; end
      4: begin asb = 1; ext = 2'b01; end
      6: begin rf = 1; wd = 2'b01; done = 1; end
      7: begin dm = 1; done = 1; end
      8: begin alu = 2'b01; ext = 2'b01; npc = 2'b01; pc = z; done = 1; end
      9: begin
        pc = 1; done = 1;
        npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin rf = 1; wr = 2'b10; wd = 2'b10; end
      end
      default: ;
    endcase
    return {pc, ir, rf, dm, npc, ext, alu, asb, wr, wd, ill, done, s4};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ir, input logic z);
    bus_a.op = ir[31:26]; bus_a.funct = ir[5:0]; bus_a.zero = z;
    bus_h.op = ir[31:26]; bus_h.funct = ir[5:0]; bus_h.zero = z;
    bus_s.op = ir[31:26]; bus_s.funct = ir[5:0]; bus_s.zero = z;
  endtask

  // Runs one instruction from FETCH, checking every cycle of all three instances.
  task automatic run_instr(input logic [31:0] ir, input logic z, output int len_obs,
                           output logic [19:0] path_obs, output int pcw, output int rfw,
                           output int dmw, output int illc, output int donec);
    kind_t k;
    int n;
    logic [20:0] exp;
    k = decode(ir);
    n = inst_len(k);
    set_ir(ir, z);
    #1;
    len_obs = 0; path_obs = '0; pcw = 0; rfw = 0; dmw = 0; illc = 0; donec = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < n) begin
        exp = outputs(path_state(k, c), k, z);
        check($sformatf("out_a ir=%h ph%0d", ir, c), 32'(obs_a), 32'(exp));
        check($sformatf("out_s ir=%h ph%0d", ir, c), 32'(obs_s), 32'(exp));
        check($sformatf("out_h ir=%h ph%0d", ir, c), 32'(obs_h),
              32'(halted ? outputs(10, k, z) : exp));
        check($sformatf("cnt_a ir=%h ph%0d", ir, c), 32'(bus_a.instr_cnt), cnt_a);
        check($sformatf("cnt_h ir=%h ph%0d", ir, c), 32'(bus_h.instr_cnt), cnt_h);
        check($sformatf("cnt_s ir=%h ph%0d", ir, c), 32'(bus_s.instr_cnt), cnt_s);
        check("rf_dm_exclusive", 32'(obs_a[18] & obs_a[17]), 32'd0);
      end else begin
        check($sformatf("overrun ir=%h", ir), c, n);
      end
      if (c < 5) path_obs[4*c +: 4] = obs_a[3:0];
      pcw   += int'(obs_a[20]);
      rfw   += int'(obs_a[18]);
      dmw   += int'(obs_a[17]);
      illc  += int'(obs_a[5]);
      donec += int'(obs_a[4]);
      len_obs++;
      if (c == n - 1) begin
        if (k != K_ILL) begin
          cnt_a++;
          if (!halted) cnt_h++;
          cnt_s = (cnt_s + 1) % 16;
        end else begin
          halted = 1'b1;
        end
      end
      step();
      if (obs_a[3:0] == 4'd0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst gates enables", 32'({obs_a[20:17], obs_a[5]}), 32'd0);
    check("rst gates enables h", 32'({obs_h[20:17], obs_h[5]}), 32'd0);
    step();
    check("rst state", 32'(obs_a[3:0]), 32'd0);
    check("rst state h", 32'(obs_h[3:0]), 32'd0);
    check("rst cnt", 32'(bus_a.instr_cnt), 32'd0);
    check("rst cnt s", 32'(bus_s.instr_cnt), 32'd0);
    check("rst holds fetch pc_wr low", 32'(obs_a[20:19]), 32'd0);
    rst = 1'b0;
    #1;
    check("fetch row after rst", 32'(obs_a), 32'(outputs(0, K_ADDU, 1'b0)));
    cnt_a = 0; cnt_h = 0; cnt_s = 0; halted = 1'b0;
  endtask

  vec_t tbl[12];
  int len_o, pcw_o, rfw_o, dmw_o, ill_o, done_o;
  logic [19:0] path_o;
  logic [31:0] rir;
  logic [31:0] legal_ops[10];

  initial begin
    tbl[0]  = '{32'h00221821, 1'b0, 4, 20'h03210, 1, 1, 0, 0, 1};  // addu
    tbl[1]  = '{32'h00221823, 1'b0, 4, 20'h03210, 1, 1, 0, 0, 1};  // subu
    tbl[2]  = '{32'h3422FFFF, 1'b1, 4, 20'h03210, 1, 1, 0, 0, 1};  // ori
    tbl[3]  = '{32'h3C021234, 1'b0, 4, 20'h03210, 1, 1, 0, 0, 1};  // lui
    tbl[4]  = '{32'h8C220004, 1'b0, 5, 20'h65410, 1, 1, 0, 0, 1};  // lw
    tbl[5]  = '{32'hAC220004, 1'b0, 4, 20'h07410, 1, 0, 1, 0, 1};  // sw
    tbl[6]  = '{32'h10220001, 1'b1, 3, 20'h00810, 2, 0, 0, 0, 1};  // beq taken
    tbl[7]  = '{32'h10220001, 1'b0, 3, 20'h00810, 1, 0, 0, 0, 1};  // beq not taken
    tbl[8]  = '{32'hFC000000, 1'b0, 2, 20'h00010, 1, 0, 0, 1, 0};  // illegal
    tbl[9]  = '{32'h0C000010, 1'b0, 3, 20'h00910, 2, 1, 0, 0, 1};  // jal
    tbl[10] = '{32'h03E00008, 1'b0, 3, 20'h00910, 2, 0, 0, 0, 1};  // jr
    tbl[11] = '{32'h08000010, 1'b1, 3, 20'h00910, 2, 0, 0, 0, 1};  // j
    legal_ops = '{32'h00000021, 32'h00000023, 32'h34000000, 32'h3C000000, 32'h8C000000,
                  32'hAC000000, 32'h10000000, 32'h08000000, 32'h0C000000, 32'h00000008};

    set_ir(32'h0, 1'b0);
    rst = 1'b1;
    step();
    do_reset();

    foreach (tbl[i]) begin
      run_instr(tbl[i].ir, tbl[i].z, len_o, path_o, pcw_o, rfw_o, dmw_o, ill_o, done_o);
      check($sformatf("tbl%0d len", i), len_o, tbl[i].len);
      check($sformatf("tbl%0d path", i), 32'(path_o), 32'(tbl[i].path));
      check($sformatf("tbl%0d pc_wr", i), pcw_o, tbl[i].pcw);
      check($sformatf("tbl%0d rf_wr", i), rfw_o, tbl[i].rfw);
      check($sformatf("tbl%0d dm_wr", i), dmw_o, tbl[i].dmw);
      check($sformatf("tbl%0d illegal", i), ill_o, tbl[i].ill);
      check($sformatf("tbl%0d done", i), done_o, tbl[i].done);
    end
    check("halt inst parked", 32'(obs_h), 32'(outputs(10, K_ILL, 1'b0)));

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(0, 11);
      if (sel < 10) begin
        rir = legal_ops[sel];
        if (sel >= 2 && sel <= 8) rir[25:0] = 26'($urandom);
        else rir[25:6] = 20'($urandom);
      end else begin
        rir = $urandom;
      end
      run_instr(rir, 1'($urandom_range(0, 1)), len_o, path_o, pcw_o, rfw_o, dmw_o, ill_o, done_o);
    end

    // Reset in MR of a lw: the load must never write back or count.
    set_ir(32'h8C220004, 1'b0);
    step(); step(); step();
    check("lw reached MR", 32'(obs_a[3:0]), 32'd5);
    do_reset();
    check("no rf_wr after abort", 32'(obs_a[18]), 32'd0);

    for (int r = 0; r < 16; r++)
      run_instr(32'h00221821, 1'b0, len_o, path_o, pcw_o, rfw_o, dmw_o, ill_o, done_o);
    check("cnt4 wrapped", 32'(bus_s.instr_cnt), 32'd0);
    check("cnt16 after 16", 32'(bus_a.instr_cnt), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath. It sequences instruction fetch from im_4k, decode, execute, memory access and write-back.
- It drives the write enables and mux selects for PC, IR, register file, data memory, extender and ALU.
- It sits beside the datapath. It reads op/funct from the IR and the ALU zero flag, and it counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0. When 0, an illegal instruction is skipped. When 1, the FSM enters S_HALT and stays there until reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- pc_wr  out  1  PC write enable.
- ir_wr  out  1  IR write enable.
- rf_wr  out  1  register file write enable.
- dm_wr  out  1  data memory write enable.
- npc_sel  out  2  next-PC source: 00 pc+4, 01 branch, 10 jump, 11 jr(rs).
- ext_op  out  2  extender mode: 00 zero, 01 sign, 10 lui (imm<<16).
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 or.
- alu_src_b  out  1  ALU B source: 0 register, 1 extended immediate.
- wr_sel  out  2  destination register: 00 rt, 01 rd, 10 $31.
- wd_sel  out  2  write-data source: 00 ALU, 01 DM, 10 pc+4.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- instr_cnt  out  CNT_W  count of retired instructions.
- state  out  4  current state, for debug.

Behaviour:
- Legal instructions:
  - R-type with op=000000: addu (funct 100001), subu (funct 100011), jr (funct 001000).
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Everything else is illegal.
- State encoding: FETCH=0, DCD=1, EXE=2, ALUWB=3, MA=4, MR=5, MEMWB=6, MW=7, BR=8, JMP=9, HALT=10.
- Reset:
  - rst sampled high leads to state=FETCH and instr_cnt=0.
  - While state=FETCH after reset, outputs follow the FETCH row. While rst is high, all write enables and illegal are forced to 0.
  - Reset mid-instruction abandons it: no partial write and no count.
- Outputs are combinational from state, op, funct and zero (Moore except BR, where pc_wr depends on zero). Every select not listed below is 0.
  - FETCH: pc_wr=1, ir_wr=1, npc_sel=00. Next state DCD.
  - DCD: no enables.
    - addu/subu/ori/lui go to EXE.
    - lw/sw go to MA.
    - beq goes to BR.
    - j/jal/jr go to JMP.
    - Illegal: illegal=1, then FETCH (or HALT if HALT_ON_ILLEGAL=1).
  - EXE:
    - addu: alu_op=00, alu_src_b=0.
    - subu: alu_op=01, alu_src_b=0.
    - ori: alu_op=10, alu_src_b=1, ext_op=00.
    - lui: alu_op=10, alu_src_b=1, ext_op=10 (rs treated as $0 by the datapath).
    - Next state ALUWB.
  - ALUWB: rf_wr=1, wd_sel=00; wr_sel=01 for R-type, 00 for ori/lui; instr_done=1. Next state FETCH.
  - MA: alu_op=00, alu_src_b=1, ext_op=01. lw goes to MR; sw goes to MW.
  - MW: dm_wr=1, instr_done=1. Next state FETCH.
  - MR: no enables. Next state MEMWB.
  - MEMWB: rf_wr=1, wd_sel=01, wr_sel=00, instr_done=1. Next state FETCH.
  - BR: alu_op=01, alu_src_b=0, ext_op=01, npc_sel=01, pc_wr=zero, instr_done=1. Next state FETCH.
  - JMP: pc_wr=1, instr_done=1. Next state FETCH.
    - j: npc_sel=10.
    - jr: npc_sel=11.
    - jal: npc_sel=10, plus rf_wr=1, wr_sel=10, wd_sel=10. pc+4 comes from the PC value held before the jump.
  - HALT: all outputs 0. Stays in HALT until rst.
- Cycle counts: beq/j/jal/jr take 3 cycles; R-type/ori/lui/sw take 4; lw takes 5.
- instr_cnt:
  - Increments by 1 on every clock edge where instr_done=1; the illegal pulse does not count.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- The FSM never writes RF and DM in the same cycle. Only FETCH and JMP/BR may assert pc_wr.

Test Plan:
1. Reset, then IR=0x00221821 (addu $3,$1,$2) -> states 0,1,2,3. In state 3: rf_wr=1, wr_sel=01, wd_sel=00. instr_cnt=1 after 4 cycles.
2. IR=0x8C220004 (lw) -> states 0,1,4,5,6. In MA: ext_op=01, alu_src_b=1. In MEMWB: rf_wr=1, wd_sel=01. IR=0xAC220004 (sw) -> dm_wr=1 for exactly one cycle, in MW.
3. IR=0x10220001 (beq) with zero=1 -> BR pc_wr=1, npc_sel=01. Repeat with zero=0 -> pc_wr=0. Both take 3 cycles and both increment instr_cnt.
4. IR=0x0C000010 (jal) -> in JMP: pc_wr=1, npc_sel=10, rf_wr=1, wr_sel=10, wd_sel=10. IR=0x03E00008 (jr $31) -> npc_sel=11.
5. IR=0xFC000000 (illegal): with HALT_ON_ILLEGAL=0 -> illegal pulses in DCD, returns to FETCH, instr_cnt unchanged. With HALT_ON_ILLEGAL=1 -> state=10 and all outputs 0 until rst.
6. Assert rst in MR of an lw -> next state FETCH, instr_cnt=0, no rf_wr. Preload CNT_W=4 and run 16 addu -> instr_cnt wraps to 0.
